// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder: keeps two row buffers and streams 3-pixel vertical columns (top, mid, bot) per pixel from row 2 on
module sobel_window_feeder #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   frame_start_i,
  input  logic                   px_rdy_i,
  input  logic [PIXEL_WIDTH-1:0] in_px_i,
  output logic                   in_ready_o,
  output logic [PIXEL_WIDTH-1:0] out_px_o,
  output logic                   px_rdy_o,
  output logic                   start_sobel_o,
  output logic                   frame_done_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  typedef enum logic [2:0] {FILL, WAIT_PX, EMIT_TOP, EMIT_MID, EMIT_BOT, ROW_GAP} state_t;
  state_t state, state_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic last_col;
  logic [PIXEL_WIDTH-1:0] line0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] mid, bot, px_n;
  logic acc, ready_n, start_n, done_n, stb_n;
  assign acc = px_rdy_i && in_ready_o && !frame_start_i;
  always_comb begin
    state_n = state;
    row_n = row;
    col_n = col;
    if (acc) begin
      col_n = (col == COL_LAST) ? '0 : col + CW'(1);
      row_n = (col != COL_LAST) ? row : (row == ROW_LAST) ? '0 : row + RW'(1);
    end
    case (state)
      FILL:     state_n = (acc && row == RW'(1) && col == COL_LAST) ? WAIT_PX : FILL;
      WAIT_PX:  state_n = acc ? EMIT_TOP : WAIT_PX;
      EMIT_TOP: state_n = EMIT_MID;
      EMIT_MID: state_n = EMIT_BOT;
      EMIT_BOT: state_n = last_col ? ROW_GAP : acc ? EMIT_TOP : WAIT_PX;
      ROW_GAP:  state_n = (row == '0) ? FILL : acc ? EMIT_TOP : WAIT_PX;
      default:  state_n = FILL;
    endcase
    if (frame_start_i) begin
      state_n = FILL;
      row_n = '0;
      col_n = '0;
    end
    stb_n = state_n inside {EMIT_TOP, EMIT_MID, EMIT_BOT};
    ready_n = !(state_n inside {EMIT_TOP, EMIT_MID}) && !(state_n == EMIT_BOT && last_col);
    px_n = (state_n == EMIT_TOP) ? line1[col] : (state_n == EMIT_MID) ? mid : (state_n == EMIT_BOT) ? bot : '0;
    // start stays high across stalls inside a row and drops only in FILL/ROW_GAP
    start_n = stb_n || (state_n == WAIT_PX && start_sobel_o);
    // row has already wrapped to 0 when the last row of the frame finishes
    done_n = state_n == ROW_GAP && row_n == '0;
  end
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state <= FILL;
      row <= '0;
      col <= '0;
      last_col <= 1'b0;
      in_ready_o <= 1'b1;
      px_rdy_o <= 1'b0;
      start_sobel_o <= 1'b0;
      frame_done_o <= 1'b0;
      out_px_o <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      col <= col_n;
      if (acc) last_col <= col == COL_LAST;
      in_ready_o <= ready_n;
      px_rdy_o <= stb_n;
      start_sobel_o <= start_n;
      frame_done_o <= done_n;
      out_px_o <= px_n;
    end
  end
  always_ff @(posedge clk_i) begin
    if (acc) begin
      line1[col] <= line0[col];
      line0[col] <= in_px_i;
      mid <= line0[col];
      bot <= in_px_i;
    end
  end
endmodule

// File: tb/tb_sobel_window_feeder.sv
// tb_sobel_window_feeder: directed table plus randomized run checked against a cycle-schedule reference model
module tb_sobel_window_feeder;
  localparam int W = 4;
  localparam int H = 4;
  localparam int NC = 4096;
  localparam int NT = 25;
  logic clk = 1'b0;
  logic nreset_i = 1'b1;
  logic frame_start_i = 1'b0;
  logic px_rdy_i = 1'b0;
  logic [7:0] in_px_i = 8'h00;
  logic [7:0] out_px_o;
  logic in_ready_o, px_rdy_o, start_sobel_o, frame_done_o;
  sobel_window_feeder #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk), .nreset_i(nreset_i), .frame_start_i(frame_start_i), .px_rdy_i(px_rdy_i),
    .in_px_i(in_px_i), .in_ready_o(in_ready_o), .out_px_o(out_px_o), .px_rdy_o(px_rdy_o),
    .start_sobel_o(start_sobel_o), .frame_done_o(frame_done_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic pr;
    logic fs;
    logic rdy;
    logic stb;
    logic st;
    logic dn;
    logic [7:0] px;
  } vec_t;
  vec_t tbl [NT];
  logic e_rdy [NC];
  logic e_stb [NC];
  logic e_st [NC];
  logic e_dn [NC];
  logic [7:0] e_px [NC];
  logic [7:0] img [H][W];
  int n = 0;
  int k = 0;
  int vectors = 0;
  int miscompares = 0;
  logic in_row = 1'b0;
  logic stb_seen, dn_seen;
  int strobes, dones;
  function automatic vec_t mk(logic pr, logic fs, logic rdy, logic stb, logic [7:0] px, logic st, logic dn);
    vec_t v;
    v.pr = pr; v.fs = fs; v.rdy = rdy; v.stb = stb; v.st = st; v.dn = dn; v.px = px;
    return v;
  endfunction
  function automatic void clr(int i);
    e_rdy[i] = 1'b1; e_stb[i] = 1'b0; e_st[i] = 1'b0; e_dn[i] = 1'b0; e_px[i] = 8'h00;
  endfunction
  function automatic void sched(int i, logic [7:0] px, logic rdy);
    e_stb[i] = 1'b1; e_px[i] = px; e_rdy[i] = rdy; e_st[i] = 1'b1;
  endfunction
  function automatic logic [7:0] pv();
    return 8'(16 * (k / W) + k % W);
  endfunction
  function automatic logic [11:0] outs();
    return {in_ready_o, px_rdy_o, start_sobel_o, frame_done_o, px_rdy_o ? out_px_o : 8'h00};
  endfunction
  task automatic cmp(string name, logic [11:0] act, logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got {rdy,stb,start,done,px}=%b,%b,%b,%b,%h want %b,%b,%b,%b,%h",
               name, n, act[11], act[10], act[9], act[8], act[7:0], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask
  task automatic step(input logic pr, input logic fs, input logic [7:0] px, input int ti);
    int r, c;
    px_rdy_i = pr;
    frame_start_i = fs;
    in_px_i = px;
    @(negedge clk);
    cmp("model", outs(), {e_rdy[n], e_stb[n], e_st[n] | in_row, e_dn[n], e_stb[n] ? e_px[n] : 8'h00});
    if (ti >= 0) cmp($sformatf("table%0d", ti), outs(), {tbl[ti].rdy, tbl[ti].stb, tbl[ti].st, tbl[ti].dn, tbl[ti].px});
    stb_seen = px_rdy_o;
    dn_seen = frame_done_o;
    if (fs) begin
      k = 0;
      in_row = 1'b0;
      for (int i = 1; i <= 8; i++) clr(n + i);
    end else if (pr && e_rdy[n]) begin
      r = k / W;
      c = k % W;
      img[r][c] = px;
      if (r >= 2) begin
        sched(n + 1, img[r-2][c], 1'b0);
        sched(n + 2, img[r-1][c], 1'b0);
        sched(n + 3, px, c != W - 1);
        if (c == W - 1) e_dn[n+4] = (r == H - 1);
        in_row = (c != W - 1);
      end
      k = (k + 1) % (W * H);
    end
    @(posedge clk);
    #1;
    n++;
  endtask
  task automatic reset_dut(input bit chk);
    #1 nreset_i = 1'b0;
    px_rdy_i = 1'b0;
    frame_start_i = 1'b0;
    #1;
    if (chk) cmp("async_reset", {in_ready_o, px_rdy_o, start_sobel_o, frame_done_o, out_px_o}, 12'h800);
    repeat (2) @(posedge clk);
    @(negedge clk) nreset_i = 1'b1;
    @(posedge clk);
    #1;
    n++;
    k = 0;
    in_row = 1'b0;
    for (int i = 0; i <= 8; i++) clr(n + i);
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < NC; i++) clr(i);
    for (int i = 0; i < 9; i++) tbl[i] = mk(1, 0, 1, 0, 8'h00, 0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 8'h00, 1, 0);
    tbl[10] = mk(1, 0, 0, 1, 8'h10, 1, 0);
    tbl[11] = mk(1, 0, 1, 1, 8'h20, 1, 0);
    tbl[12] = mk(1, 0, 0, 1, 8'h01, 1, 0);
    tbl[13] = mk(1, 0, 0, 1, 8'h11, 1, 0);
    tbl[14] = mk(1, 0, 1, 1, 8'h21, 1, 0);
    tbl[15] = mk(1, 0, 0, 1, 8'h02, 1, 0);
    tbl[16] = mk(1, 0, 0, 1, 8'h12, 1, 0);
    tbl[17] = mk(1, 0, 1, 1, 8'h22, 1, 0);
    tbl[18] = mk(1, 0, 0, 1, 8'h03, 1, 0);
    tbl[19] = mk(1, 0, 0, 1, 8'h13, 1, 0);
    tbl[20] = mk(1, 0, 0, 1, 8'h23, 1, 0);
    tbl[21] = mk(1, 0, 1, 0, 8'h00, 0, 0);
    tbl[22] = mk(1, 0, 0, 1, 8'h10, 1, 0);
    tbl[23] = mk(1, 1, 0, 1, 8'h20, 1, 0);
    tbl[24] = mk(1, 0, 1, 0, 8'h00, 0, 0);
    reset_dut(1'b1);
    for (int i = 0; i < NT; i++) step(tbl[i].pr, tbl[i].fs, pv(), i);
    strobes = 0;
    dones = 0;
    for (int i = 0; i < 100 && dones == 0; i++) begin
      step(1'b1, 1'b0, pv(), -1);
      strobes += int'(stb_seen);
      dones += int'(dn_seen);
    end
    cmp("frame_strobes", 12'(strobes), 12'd24);
    cmp("frame_done_pulses", 12'(dones), 12'd1);
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, pv(), -1);
      strobes += int'(stb_seen);
    end
    cmp("post_frame_strobes", 12'(strobes), 12'd0);
    reset_dut(1'b1);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0, 8'($urandom), -1);
      if (i == 1500) reset_dut(1'b1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sobel_window_feeder.md
Name: sobel_window_feeder

Overview:
- Upstream neighbour of the Sobel control/core stage.
- Accepts grayscale pixels in raster order and keeps the two previous image rows in on-chip line buffers.
- For every pixel from row 2 onward, emits one 3-pixel vertical column (rows r-2, r-1, r) as a serial strobed stream. This matches the column-by-column 3x3 window fill the Sobel stage expects.
- Frames each image row with start_sobel_o so the Sobel stage restarts its window at every row.

Parameters:
- PIXEL_WIDTH, 8, bits per grayscale pixel in and out.
- IMG_WIDTH, 16, pixels per row; must be at least 3.
- IMG_HEIGHT, 16, rows per frame; must be at least 3.

Ports:
- clk_i  input  1  clock.
- nreset_i  input  1  reset; asynchronous assertion, active-low.
- frame_start_i  input  1  single-cycle pulse; aborts current work and restarts at pixel (0,0).
- px_rdy_i  input  1  input pixel valid strobe.
- in_px_i  input  PIXEL_WIDTH  input pixel.
- in_ready_o  output  1  block can accept a pixel this cycle.
- out_px_o  output  PIXEL_WIDTH  output pixel, meaningful only while px_rdy_o=1.
- px_rdy_o  output  1  single-cycle strobe per output pixel.
- start_sobel_o  output  1  high while a row's column stream is active.
- frame_done_o  output  1  single-cycle pulse after the last column of the frame.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on nreset_i.
- Reset values:
  - state=FILL, row=0, col=0.
  - in_ready_o=1, px_rdy_o=0, start_sobel_o=0, frame_done_o=0, out_px_o=0.
  - Line buffer contents are don't-care.
- All outputs are registered.
- Accept rule: a pixel is accepted on the rising edge where px_rdy_i=1 and in_ready_o=1. px_rdy_i while in_ready_o=0 is ignored (the pixel is lost, no error flag).
- On accept of pixel (r,c):
  - line1[c] <= line0[c]; line0[c] <= in_px_i.
  - If r>=2, latch top=line1[c], mid=line0[c], bot=in_px_i (old values, i.e. rows r-2 and r-1).
  - col increments. At col=IMG_WIDTH-1 it wraps to 0 and row increments.
- FSM states: FILL, WAIT_PX, EMIT_TOP, EMIT_MID, EMIT_BOT, ROW_GAP.
- FILL (rows 0 and 1):
  - in_ready_o=1; no output strobes.
  - After accepting pixel (1,IMG_WIDTH-1) -> WAIT_PX.
- WAIT_PX:
  - in_ready_o=1.
  - On accept of (r,c) -> EMIT_TOP.
- EMIT_TOP: out_px_o=top, px_rdy_o=1, in_ready_o=0 -> EMIT_MID.
- EMIT_MID: out_px_o=mid, px_rdy_o=1, in_ready_o=0 -> EMIT_BOT.
- EMIT_BOT: out_px_o=bot, px_rdy_o=1.
  - If c<IMG_WIDTH-1: in_ready_o=1. An accept here -> EMIT_TOP (back-to-back columns); otherwise -> WAIT_PX.
  - If c=IMG_WIDTH-1: in_ready_o=0 -> ROW_GAP.
- ROW_GAP: exactly one cycle; start_sobel_o=0, px_rdy_o=0, in_ready_o=1.
  - If the finished row was IMG_HEIGHT-1: frame_done_o=1 this cycle, row/col reset to 0, -> FILL. A pixel accepted here is (0,0).
  - Otherwise: an accept -> EMIT_TOP; no accept -> WAIT_PX.
- Latency: accept at edge T gives top at cycle T+1, mid at T+2, bot at T+3.
- Peak throughput: 1 pixel per 3 cycles within a row; 1 extra gap cycle per row.
- start_sobel_o:
  - Rises together with the top strobe of column 0 of each row r>=2.
  - Stays high through the bot strobe of column IMG_WIDTH-1.
  - Is low in ROW_GAP, so every row restart sees at least one low cycle.
  - Remains high in WAIT_PX stalls inside a row.
- Per row r>=2, exactly 3*IMG_WIDTH px_rdy_o strobes. Per frame, (IMG_HEIGHT-2) rows are emitted.
- frame_start_i:
  - Has priority over everything.
  - Next cycle: state=FILL, row=col=0, px_rdy_o=0, start_sobel_o=0, frame_done_o=0, in_ready_o=1.
  - A pixel presented in the same cycle as frame_start_i is dropped.
  - Asserting it mid-emission truncates the column; no further strobes follow.
- Asynchronous reset mid-operation: immediately forces the reset values above.

Test Plan:
- Use IMG_WIDTH=4, IMG_HEIGHT=4 and pixel value = 16*r+c in all scenarios.
- Rows 0 and 1 fed continuously: 8 accepts, px_rdy_o never asserts, in_ready_o stays 1.
- Row 2, pixel (2,0): strobes 0x00, 0x10, 0x20 on consecutive cycles T+1..T+3; start_sobel_o rises at T+1.
- Row 2 fed back-to-back at every in_ready_o: 12 strobes, last column 0x03, 0x13, 0x23; in_ready_o low in the last EMIT_BOT cycle; start_sobel_o low for exactly 1 cycle (ROW_GAP).
- Full frame: 24 strobes total; frame_done_o pulses once in the ROW_GAP after pixel (3,3)'s bot (0x33); the following 8 pixels produce no output.
- Pulse frame_start_i during EMIT_MID of row 3: no EMIT_BOT strobe; start_sobel_o=0 next cycle; the next 8 pixels produce no output.
- px_rdy_i held high throughout: only accepts where in_ready_o=1 are taken; output sequence is identical to the back-to-back case.
